// File: rtl/block_memory_responder.sv
// block_memory_responder
//   Single-ported DEPTH x 64-bit block store shared by an instruction-fill port
//   and a data port. One access is in service at a time. The data port wins
//   arbitration in IDLE. Data becomes valid LATENCY-2 edges after the accept
//   edge, and stays valid while the owner holds its request and address.
//   DEPTH is expected to be a power of two, so addresses wrap on their low bits.
//
//   Ports
//     clk            rising-edge clock
//     reset_n        asynchronous active-low reset (array contents untouched)
//     i_readM        instruction read request, level-held
//     i_address_mem  instruction block address
//     i_data_mem     instruction block data, 0 unless i_ready
//     i_ready        i_data_mem valid for the current i_address_mem
//     d_readM        data read request, level-held
//     d_writeM       data write request, level-held (wins over d_readM)
//     d_address_mem  data block address
//     d_wdata        write block data, sampled on the commit edge
//     d_rdata        read block data, 0 unless a read is ready
//     d_ready        read data valid, or write committed
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access in service, arbitration happens here
//   I_BUSY | instruction read in service, cnt counts down to data valid
//   D_BUSY | data read/write in service, write commits on cnt 1->0
module block_memory_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 16384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_readM,
    input  logic [13:0] i_address_mem,
    output logic [63:0] i_data_mem,
    output logic        i_ready,
    input  logic        d_readM,
    input  logic        d_writeM,
    input  logic [13:0] d_address_mem,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ready
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_q, wr_d;

    logic [63:0]     mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;

    logic            d_req;
    logic [AW-1:0]   i_addr;
    logic [AW-1:0]   d_addr;
    logic [63:0]     rd_data;

    assign d_req  = d_readM | d_writeM;
    assign i_addr = i_address_mem[AW-1:0];
    assign d_addr = d_address_mem[AW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    wr_d    = d_writeM;
                    cnt_d   = CNT_LOAD;
                    // With no wait cycles the write lands on the accept edge.
                    if (LATENCY == 2 && d_writeM) begin
                        mem_we    = 1'b1;
                        mem_waddr = d_addr;
                    end
                end else if (i_readM) begin
                    state_d = I_BUSY;
                    addr_d  = i_addr;
                    wr_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                end
            end

            I_BUSY: begin
                if (!i_readM) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (i_addr != addr_q) begin
                    addr_d = i_addr;
                    cnt_d  = CNT_LOAD;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            D_BUSY: begin
                if (!d_req) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (d_addr != addr_q || d_writeM != wr_q) begin
                    // A changed address or op is a fresh access in place.
                    addr_d = d_addr;
                    wr_d   = d_writeM;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 2 && d_writeM) begin
                        mem_we    = 1'b1;
                        mem_waddr = d_addr;
                    end
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                    // Commit only on the 1->0 step, so a held request
                    // sitting at cnt=0 never writes a second time.
                    if (cnt_q == 3'd1 && wr_q) begin
                        mem_we = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    // Storage is deliberately outside the reset domain. The reset_n term stops
    // a write from landing on an edge taken while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            mem_q[mem_waddr] <= d_wdata;
        end
    end

    assign rd_data = mem_q[addr_q];

    // Ready also checks the live request and address. This drops ready in the
    // same cycle the requester moves away, not one edge later.
    assign i_ready = (state_q == I_BUSY) && (cnt_q == 3'd0) && i_readM &&
                     (i_addr == addr_q);
    assign d_ready = (state_q == D_BUSY) && (cnt_q == 3'd0) && d_req &&
                     (d_addr == addr_q) && (d_writeM == wr_q);

    assign i_data_mem = i_ready ? rd_data : 64'h0;
    assign d_rdata    = (d_ready && !wr_q) ? rd_data : 64'h0;

endmodule

// File: tb/tb_block_memory_responder.sv
// tb_block_memory_responder
//   Directed stimulus for block_memory_responder at LATENCY=4. Each stimulus
//   step queues the response it expects. A negedge monitor pops and compares
//   whenever a ready output rises, and checks that data outputs are zero
//   whenever ready is low. Latency counts are checked inline by the stimulus.
module tb_block_memory_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_readM = 1'b0;
    logic [13:0] i_address_mem = '0;
    logic [63:0] i_data_mem;
    logic        i_ready;
    logic        d_readM = 1'b0;
    logic        d_writeM = 1'b0;
    logic [13:0] d_address_mem = '0;
    logic [63:0] d_wdata = '0;
    logic [63:0] d_rdata;
    logic        d_ready;

    localparam logic [63:0] V1   = 64'h1111_2222_3333_0001;
    localparam logic [63:0] V2   = 64'h2222_3333_4444_0002;
    localparam logic [63:0] V3   = 64'h3333_4444_5555_0003;
    localparam logic [63:0] V4   = 64'h4444_5555_6666_0004;
    localparam logic [63:0] V5   = 64'h5555_6666_7777_0005;
    localparam logic [63:0] V6   = 64'h6666_7777_8888_0006;
    localparam logic [63:0] V10  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V20  = 64'hCAFE_F00D_0000_0020;
    localparam logic [63:0] V30  = 64'h5A5A_A5A5_0000_0030;

    block_memory_responder #(.LATENCY(4), .DEPTH(16384)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_readM       (i_readM),
        .i_address_mem (i_address_mem),
        .i_data_mem    (i_data_mem),
        .i_ready       (i_ready),
        .d_readM       (d_readM),
        .d_writeM      (d_writeM),
        .d_address_mem (d_address_mem),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_ready       (d_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        bit          is_write;
    } exp_t;

    exp_t i_exp[$];
    exp_t d_exp[$];
    bit   i_prev = 1'b0;
    bit   d_prev = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare on every rising ready, and check zero outputs while idle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_ready && !i_prev) begin
                if (i_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL i_unexpected: i_ready rose with data %h, no response expected", i_data_mem);
                end else begin
                    exp_t e;
                    e = i_exp.pop_front();
                    check64("i_data", i_data_mem, e.data);
                end
            end
            if (d_ready && !d_prev) begin
                if (d_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d_unexpected: d_ready rose with data %h, no response expected", d_rdata);
                end else begin
                    exp_t e;
                    e = d_exp.pop_front();
                    if (!e.is_write) check64("d_rdata", d_rdata, e.data);
                end
            end
            if (!i_ready) check64("i_zero_when_not_ready", i_data_mem, 64'h0);
            if (!d_ready) check64("d_zero_when_not_ready", d_rdata, 64'h0);
        end
        i_prev = i_ready;
        d_prev = d_ready;
    end

    // Counts posedges until the selected ready is seen at a negedge; -1 on timeout.
    task automatic wait_ready(input bit dport, input int max_edges, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < max_edges) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = dport ? d_ready : i_ready;
        end
        if (!seen) n = -1;
    endtask

    // Drop every request one edge later, then wait one more edge so the FSM is IDLE.
    task automatic release_all();
        @(posedge clk);
        #1;
        i_readM  = 1'b0;
        d_readM  = 1'b0;
        d_writeM = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [63:0] data, input string nm);
        int n;
        d_exp.push_back('{data, 1'b1});
        d_address_mem = addr;
        d_wdata       = data;
        d_writeM      = 1'b1;
        wait_ready(1'b1, 20, n);
        check_int(nm, n, 3);
        release_all();
    endtask

    task automatic do_dread(input logic [13:0] addr, input logic [63:0] data, input string nm);
        int n;
        d_exp.push_back('{data, 1'b0});
        d_address_mem = addr;
        d_readM       = 1'b1;
        wait_ready(1'b1, 20, n);
        check_int(nm, n, 3);
        release_all();
    endtask

    task automatic do_iread(input logic [13:0] addr, input logic [63:0] data, input string nm);
        int n;
        i_exp.push_back('{data, 1'b0});
        i_address_mem = addr;
        i_readM       = 1'b1;
        wait_ready(1'b0, 20, n);
        check_int(nm, n, 3);
        release_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        #12;
        check_int("rst_i_ready", int'(i_ready), 0);
        check_int("rst_d_ready", int'(d_ready), 0);
        check64("rst_i_data", i_data_mem, 64'h0);
        check64("rst_d_rdata", d_rdata, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload
        do_write(14'h0001, V1, "wr1_lat");
        do_write(14'h0002, V2, "wr2_lat");
        do_write(14'h0003, V3, "wr3_lat");
        do_write(14'h0004, V4, "wr4_lat");
        do_write(14'h0005, V5, "wr5_lat");
        do_write(14'h0006, V6, "wr6_lat");
        do_write(14'h0020, V20, "wr20_lat");

        // Write then instruction read-back
        do_write(14'h0010, V10, "wr10_lat");
        do_iread(14'h0010, V10, "ird10_lat");

        // Simultaneous requests: data first, instruction afterwards
        d_exp.push_back('{V2, 1'b0});
        i_exp.push_back('{V1, 1'b0});
        i_address_mem = 14'h0001;
        d_address_mem = 14'h0002;
        i_readM = 1'b1;
        d_readM = 1'b1;
        wait_ready(1'b1, 20, n);
        check_int("arb_d_lat", n, 3);
        check_int("arb_i_waits", int'(i_ready), 0);
        @(posedge clk);
        #1;
        d_readM = 1'b0;
        wait_ready(1'b0, 20, n);
        check_int("arb_i_lat", n, 4);
        release_all();

        // Instruction read dropped after one edge, then a new read
        i_exp.push_back('{V6, 1'b0});
        i_address_mem = 14'h0005;
        i_readM = 1'b1;
        @(posedge clk);
        #1;
        i_readM = 1'b0;
        @(posedge clk);
        #1;
        i_address_mem = 14'h0006;
        i_readM = 1'b1;
        wait_ready(1'b0, 20, n);
        check_int("drop_i_lat", n, 3);
        release_all();

        // Write aborted at cnt=1
        d_address_mem = 14'h0020;
        d_wdata = 64'h0000_0000_0000_FFFF;
        d_writeM = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        d_writeM = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_int("abort_no_d_ready", int'(d_ready), 0);
        end
        @(posedge clk);
        #1;
        do_dread(14'h0020, V20, "abort_rd_lat");

        // Reset mid-I_BUSY while data is being presented
        i_exp.push_back('{V3, 1'b0});
        i_address_mem = 14'h0003;
        i_readM = 1'b1;
        wait_ready(1'b0, 20, n);
        check_int("pre_rst_lat", n, 3);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_int("mid_rst_i_ready", int'(i_ready), 0);
        check64("mid_rst_i_data", i_data_mem, 64'h0);
        check_int("mid_rst_d_ready", int'(d_ready), 0);
        check64("mid_rst_d_rdata", d_rdata, 64'h0);
        i_readM = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_iread(14'h0003, V3, "post_rst_i_lat");
        do_dread(14'h0010, V10, "post_rst_d_lat");

        // Instruction address change while cnt=1
        i_exp.push_back('{V4, 1'b0});
        i_address_mem = 14'h0003;
        i_readM = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_address_mem = 14'h0004;
        wait_ready(1'b0, 20, n);
        check_int("relatch_lat", n, 3);
        release_all();

        // Read and write together act as a write
        d_exp.push_back('{V30, 1'b1});
        d_address_mem = 14'h0030;
        d_wdata = V30;
        d_readM = 1'b1;
        d_writeM = 1'b1;
        wait_ready(1'b1, 20, n);
        check_int("rw_lat", n, 3);
        release_all();
        do_dread(14'h0030, V30, "rw_rd_lat");

        @(negedge clk);
        check_int("i_queue_empty", i_exp.size(), 0);
        check_int("d_queue_empty", d_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
